// File: rtl/cmp_stream_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_stream_scheduler
//  Purpose  : Serialises the per-component compressed tile streams into one
//             AXI-stream codestream frame for the JP2 bit assembler. Components
//             are served strictly in order 0..N_CMP-1, one packet each, and the
//             forwarded payload bytes are counted for Psot / box lengths.
//  Ports    : clk, rst_n           - clock, async active-low reset
//             start_i              - one-cycle pulse, begins a frame
//             busy_o, done_o       - frame in progress / final beat accepted
//             cmp_sel_o            - component currently served
//             byte_cnt_o           - bytes accepted in current/last frame
//             s_axis_cmp_*         - packed per-component source streams
//             m_axis_tx_*          - codestream output to the bit assembler
//  Revision : 1.0 - initial release
// ============================================================================
module cmp_stream_scheduler #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8,
    parameter int N_CMP  = 3,
    parameter int CNT_W  = 32,
    parameter int SEL_W  = (N_CMP > 1) ? $clog2(N_CMP) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [SEL_W-1:0]           cmp_sel_o,
    output logic [CNT_W-1:0]           byte_cnt_o,
    input  logic [N_CMP-1:0]           s_axis_cmp_valid_i,
    input  logic [N_CMP-1:0]           s_axis_cmp_last_i,
    input  logic [N_CMP*DATA_W-1:0]    s_axis_cmp_data_i,
    input  logic [N_CMP*KEEP_W-1:0]    s_axis_cmp_keep_i,
    output logic [N_CMP-1:0]           s_axis_cmp_ready_o,
    output logic                       m_axis_tx_valid_o,
    output logic                       m_axis_tx_last_o,
    output logic [DATA_W-1:0]          m_axis_tx_data_o,
    output logic [KEEP_W-1:0]          m_axis_tx_keep_o,
    input  logic                       m_axis_tx_ready_i
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t              state_q;
    logic                busy_q;
    logic                done_q;
    logic [SEL_W-1:0]    cmp_sel_q;
    logic [CNT_W-1:0]    byte_cnt_q;
    logic                m_valid_q;
    logic                m_last_q;
    logic [DATA_W-1:0]   m_data_q;
    logic [KEEP_W-1:0]   m_keep_q;

    logic                w_sel_valid;
    logic                w_sel_last;
    logic [DATA_W-1:0]   w_sel_data;
    logic [KEEP_W-1:0]   w_sel_keep;
    logic [CNT_W-1:0]    w_keep_bytes;
    logic                w_out_free;
    logic                w_streaming;
    logic                w_accept;
    logic                w_final_cmp;
    logic [N_CMP-1:0]    w_s_ready;

    // Mux the currently served component onto a single beat.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        w_sel_keep  = '0;
        for (int k = 0; k < N_CMP; k++) begin
            if (cmp_sel_q == SEL_W'(k)) begin
                w_sel_valid = s_axis_cmp_valid_i[k];
                w_sel_last  = s_axis_cmp_last_i[k];
                w_sel_data  = s_axis_cmp_data_i[k*DATA_W +: DATA_W];
                w_sel_keep  = s_axis_cmp_keep_i[k*KEEP_W +: KEEP_W];
            end
        end
    end

    // Byte enables need not be contiguous, so count every set bit.
    always_comb begin
        w_keep_bytes = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            w_keep_bytes = w_keep_bytes + CNT_W'(w_sel_keep[b]);
        end
    end

    // The single output register can take a new beat when empty or draining
    // this cycle; this keeps full throughput without a skid buffer.
    assign w_out_free  = ~m_valid_q | m_axis_tx_ready_i;
    assign w_streaming = (state_q == ST_STREAM);
    assign w_accept    = w_streaming & w_sel_valid & w_out_free;
    assign w_final_cmp = (cmp_sel_q == SEL_W'(N_CMP - 1));

    always_comb begin
        w_s_ready = '0;
        for (int k = 0; k < N_CMP; k++) begin
            w_s_ready[k] = w_streaming && (cmp_sel_q == SEL_W'(k)) && w_out_free;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cmp_sel_q  <= '0;
            byte_cnt_q <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
        end else begin
            done_q <= 1'b0;

            // Output register empties on a downstream handshake; contents
            // hold while stalled.
            if (m_valid_q && m_axis_tx_ready_i) begin
                m_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        cmp_sel_q  <= '0;
                        byte_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_STREAM;
                    end
                end

                ST_STREAM: begin
                    if (w_accept) begin
                        m_valid_q  <= 1'b1;
                        m_data_q   <= w_sel_data;
                        m_keep_q   <= w_sel_keep;
                        // Only the last component's end-of-packet ends the frame.
                        m_last_q   <= w_sel_last & w_final_cmp;
                        byte_cnt_q <= byte_cnt_q + w_keep_bytes;
                        if (w_sel_last) begin
                            if (w_final_cmp) begin
                                state_q <= ST_DRAIN;
                            end else begin
                                cmp_sel_q <= cmp_sel_q + SEL_W'(1);
                            end
                        end
                    end
                end

                ST_DRAIN: begin
                    if (m_valid_q && m_axis_tx_ready_i) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign cmp_sel_o          = cmp_sel_q;
    assign byte_cnt_o         = byte_cnt_q;
    assign s_axis_cmp_ready_o = w_s_ready;
    assign m_axis_tx_valid_o  = m_valid_q;
    assign m_axis_tx_last_o   = m_last_q;
    assign m_axis_tx_data_o   = m_data_q;
    assign m_axis_tx_keep_o   = m_keep_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_stream_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_cmp_stream_scheduler
//  Purpose  : Self-checking bench for cmp_stream_scheduler (3 components,
//             32-bit data). A transaction-level model predicts ready, output
//             beats, byte count, busy/done and component select every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cmp_stream_scheduler;

    localparam int DATA_W = 32;
    localparam int KEEP_W = 4;
    localparam int N_CMP  = 3;
    localparam int CNT_W  = 32;
    localparam int SEL_W  = 2;
    localparam int MAXB   = 8;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start_i = 1'b0;
    logic                    busy_o;
    logic                    done_o;
    logic [SEL_W-1:0]        cmp_sel_o;
    logic [CNT_W-1:0]        byte_cnt_o;
    logic [N_CMP-1:0]        s_axis_cmp_valid_i = '0;
    logic [N_CMP-1:0]        s_axis_cmp_last_i = '0;
    logic [N_CMP*DATA_W-1:0] s_axis_cmp_data_i = '0;
    logic [N_CMP*KEEP_W-1:0] s_axis_cmp_keep_i = '0;
    logic [N_CMP-1:0]        s_axis_cmp_ready_o;
    logic                    m_axis_tx_valid_o;
    logic                    m_axis_tx_last_o;
    logic [DATA_W-1:0]       m_axis_tx_data_o;
    logic [KEEP_W-1:0]       m_axis_tx_keep_o;
    logic                    m_axis_tx_ready_i = 1'b0;

    cmp_stream_scheduler #(
        .DATA_W(DATA_W), .KEEP_W(KEEP_W), .N_CMP(N_CMP), .CNT_W(CNT_W), .SEL_W(SEL_W)
    ) u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start_i            (start_i),
        .busy_o             (busy_o),
        .done_o             (done_o),
        .cmp_sel_o          (cmp_sel_o),
        .byte_cnt_o         (byte_cnt_o),
        .s_axis_cmp_valid_i (s_axis_cmp_valid_i),
        .s_axis_cmp_last_i  (s_axis_cmp_last_i),
        .s_axis_cmp_data_i  (s_axis_cmp_data_i),
        .s_axis_cmp_keep_i  (s_axis_cmp_keep_i),
        .s_axis_cmp_ready_o (s_axis_cmp_ready_o),
        .m_axis_tx_valid_o  (m_axis_tx_valid_o),
        .m_axis_tx_last_o   (m_axis_tx_last_o),
        .m_axis_tx_data_o   (m_axis_tx_data_o),
        .m_axis_tx_keep_o   (m_axis_tx_keep_o),
        .m_axis_tx_ready_i  (m_axis_tx_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    // Source stimulus tables
    beat_t sb [N_CMP][MAXB];
    int    sn [N_CMP];
    int    sp [N_CMP];
    int    en_cyc [N_CMP];
    int    cyc = 0;
    int    rdy_mode = 0;
    logic [N_CMP-1:0] hs;
    logic  done_neg = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: beats accepted from sources but not yet taken downstream,
    // frame progress in packets, and expected byte count / busy / done.
    // ------------------------------------------------------------------
    beat_t            exp_q[$];
    int               pk_done = 0;
    bit               m_busy = 0;
    bit               exp_done = 0;
    bit               fin;
    logic [CNT_W-1:0] m_cnt = '0;
    int               out_beats = 0;
    logic [N_CMP-1:0] exp_rdy;
    beat_t            nb;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_ctrl", {busy_o, done_o, cmp_sel_o, s_axis_cmp_ready_o,
                               m_axis_tx_valid_o, m_axis_tx_last_o, m_axis_tx_keep_o}, 0);
            check("rst_cnt", byte_cnt_o, 0);
            check("rst_data", m_axis_tx_data_o, 0);
            exp_q.delete();
            pk_done  = 0;
            m_busy   = 0;
            exp_done = 0;
            m_cnt    = '0;
        end else begin
            for (int k = 0; k < N_CMP; k++) begin
                exp_rdy[k] = m_busy && (pk_done < N_CMP) && (k == pk_done) &&
                             ((exp_q.size() == 0) || m_axis_tx_ready_i);
            end
            check("s_ready", s_axis_cmp_ready_o, exp_rdy);
            check("m_valid", m_axis_tx_valid_o, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("m_data", m_axis_tx_data_o, exp_q[0].data);
                check("m_keep", m_axis_tx_keep_o, exp_q[0].keep);
                check("m_last", m_axis_tx_last_o, exp_q[0].last);
            end
            check("busy", busy_o, m_busy);
            check("done", done_o, exp_done);
            check("cmp_sel", cmp_sel_o, (pk_done < N_CMP) ? pk_done : N_CMP - 1);
            check("byte_cnt", byte_cnt_o, m_cnt);

            // Advance the model across the coming edge.
            fin = 0;
            if (exp_q.size() != 0 && m_axis_tx_ready_i) begin
                fin = exp_q[0].last;
                void'(exp_q.pop_front());
                out_beats++;
            end
            for (int k = 0; k < N_CMP; k++) begin
                if (exp_rdy[k] && s_axis_cmp_valid_i[k]) begin
                    nb.data = s_axis_cmp_data_i[k*DATA_W +: DATA_W];
                    nb.keep = s_axis_cmp_keep_i[k*KEEP_W +: KEEP_W];
                    nb.last = s_axis_cmp_last_i[k] && (k == N_CMP - 1);
                    exp_q.push_back(nb);
                    m_cnt = m_cnt + CNT_W'($countones(nb.keep));
                    if (s_axis_cmp_last_i[k]) pk_done++;
                end
            end
            if (start_i && !m_busy) begin
                m_busy  = 1;
                pk_done = 0;
                m_cnt   = '0;
            end
            if (exp_done) m_busy = 0;
            exp_done = fin;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive();
        for (int k = 0; k < N_CMP; k++) begin
            if (cyc >= en_cyc[k] && sp[k] < sn[k]) begin
                s_axis_cmp_valid_i[k]                 = 1'b1;
                s_axis_cmp_last_i[k]                  = sb[k][sp[k]].last;
                s_axis_cmp_data_i[k*DATA_W +: DATA_W] = sb[k][sp[k]].data;
                s_axis_cmp_keep_i[k*KEEP_W +: KEEP_W] = sb[k][sp[k]].keep;
            end else begin
                s_axis_cmp_valid_i[k]                 = 1'b0;
                s_axis_cmp_last_i[k]                  = 1'b0;
                s_axis_cmp_data_i[k*DATA_W +: DATA_W] = '0;
                s_axis_cmp_keep_i[k*KEEP_W +: KEEP_W] = '0;
            end
        end
        m_axis_tx_ready_i = (rdy_mode == 0) ? 1'b1 : cyc[0];
    endtask

    task automatic step();
        @(negedge clk);
        hs       = s_axis_cmp_valid_i & s_axis_cmp_ready_o;
        done_neg = done_o;
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < N_CMP; k++) begin
            if (hs[k]) sp[k]++;
        end
        drive();
    endtask

    task automatic load_src(input int k, input int nbeats, input logic [KEEP_W-1:0] keep_last,
                            input int delay, input int fid);
        for (int i = 0; i < nbeats; i++) begin
            sb[k][i].data = {8'(fid), 8'(k), 8'(i), 8'hA5};
            sb[k][i].keep = (i == nbeats - 1) ? keep_last : 4'hF;
            sb[k][i].last = (i == nbeats - 1);
        end
        sn[k]     = nbeats;
        sp[k]     = 0;
        en_cyc[k] = cyc + delay;
    endtask

    task automatic run_frame(input int budget, input int mid, output int n);
        bit seen;
        seen    = 0;
        n       = 0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("start_busy", busy_o, 1);
        check("start_sel", cmp_sel_o, 0);
        check("start_cnt", byte_cnt_o, 0);
        while (!seen && n < budget) begin
            start_i = (n == mid);
            step();
            n++;
            if (done_neg) seen = 1;
        end
        start_i = 1'b0;
        check("done_timeout", seen, 1);
    endtask

    int n_cyc;
    int ob0;
    int guard;

    initial begin
        drive();
        // Reset state
        repeat (3) step();
        check("reset_busy", busy_o, 0);
        check("reset_cnt", byte_cnt_o, 0);
        check("reset_valid", m_axis_tx_valid_o, 0);
        rst_n = 1'b1;
        repeat (2) step();
        check("idle_ready", s_axis_cmp_ready_o, 0);

        // Basic frame: 2,3,1 full beats
        rdy_mode = 0;
        load_src(0, 2, 4'hF, 0, 1);
        load_src(1, 3, 4'hF, 0, 1);
        load_src(2, 1, 4'hF, 0, 1);
        ob0 = out_beats;
        run_frame(60, -1, n_cyc);
        check("basic_latency", n_cyc, 8);
        check("basic_bytes", byte_cnt_o, 24);
        check("basic_beats", out_beats - ob0, 6);
        check("basic_sel_hold", cmp_sel_o, 2);
        repeat (2) step();
        check("basic_idle_busy", busy_o, 0);

        // Partial keep on single-beat packets
        load_src(0, 1, 4'b0001, 0, 2);
        load_src(1, 1, 4'b0011, 0, 2);
        load_src(2, 1, 4'b0111, 0, 2);
        run_frame(60, -1, n_cyc);
        check("partial_bytes", byte_cnt_o, 6);
        repeat (2) step();

        // Backpressure: downstream ready toggles every cycle
        rdy_mode = 1;
        load_src(0, 2, 4'hF, 0, 3);
        load_src(1, 3, 4'hF, 0, 3);
        load_src(2, 1, 4'hF, 0, 3);
        ob0 = out_beats;
        run_frame(100, -1, n_cyc);
        check("bp_bytes", byte_cnt_o, 24);
        check("bp_beats", out_beats - ob0, 6);
        rdy_mode = 0;
        repeat (2) step();

        // Ordering: source 2 valid early, source 0 late
        load_src(0, 2, 4'hF, 6, 4);
        load_src(1, 1, 4'b1010, 0, 4);
        load_src(2, 2, 4'b1000, 0, 4);
        run_frame(80, -1, n_cyc);
        check("order_bytes", byte_cnt_o, 15);
        repeat (2) step();

        // Start pulsed mid-frame is ignored
        load_src(0, 2, 4'hF, 0, 5);
        load_src(1, 3, 4'hF, 0, 5);
        load_src(2, 1, 4'b0001, 0, 5);
        run_frame(60, 3, n_cyc);
        check("midstart_latency", n_cyc, 8);
        check("midstart_bytes", byte_cnt_o, 21);
        repeat (2) step();

        // Reset during component 1
        load_src(0, 1, 4'hF, 0, 6);
        load_src(1, 3, 4'hF, 0, 6);
        load_src(2, 1, 4'hF, 0, 6);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        guard = 0;
        while (cmp_sel_o != 2'd1 && guard < 20) begin
            step();
            guard++;
        end
        check("reach_cmp1", cmp_sel_o, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", busy_o, 0);
        check("rst_mid_cnt", byte_cnt_o, 0);
        check("rst_mid_valid", m_axis_tx_valid_o, 0);
        check("rst_mid_ready", s_axis_cmp_ready_o, 0);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        check("rst_no_done", done_o, 0);

        // Fresh frame after reset
        load_src(0, 2, 4'hF, 0, 7);
        load_src(1, 3, 4'hF, 0, 7);
        load_src(2, 1, 4'hF, 0, 7);
        run_frame(60, -1, n_cyc);
        check("post_rst_bytes", byte_cnt_o, 24);
        check("post_rst_latency", n_cyc, 8);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cmp_stream_scheduler.md
Name: cmp_stream_scheduler

Overview:
- Sequences the per-component compressed tile streams (Y/Cb/Cr entropy coders) into the single AXI-stream codestream input of the JP2 bit assembler.
- Serves components strictly in order 0..N_CMP-1, one complete packet each, and produces one contiguous codestream frame per start.
- Counts the forwarded payload bytes so the assembler can fill tile-part length (Psot) and codestream box length fields.
- Sits between the component encoders and the bit assembler; started once per tile by the top-level encoder control.

Parameters:
- DATA_W, 32, stream data width in bits (multiple of 8)
- KEEP_W, DATA_W/8, byte-enable width
- N_CMP, 3, number of component sources (1..8)
- CNT_W, 32, byte counter width
- SEL_W, (N_CMP>1 ? $clog2(N_CMP) : 1), component select width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start_i  in  1  one-cycle pulse, begins a frame
- busy_o  out  1  high from accepted start until done_o
- done_o  out  1  one-cycle pulse when final beat accepted downstream
- cmp_sel_o  out  SEL_W  index of component currently served
- byte_cnt_o  out  CNT_W  bytes accepted from sources in current/last frame
- s_axis_cmp_valid_i  in  N_CMP  per-source valid
- s_axis_cmp_last_i  in  N_CMP  per-source end of packet
- s_axis_cmp_data_i  in  N_CMP*DATA_W  packed data, source k at [k*DATA_W +: DATA_W]
- s_axis_cmp_keep_i  in  N_CMP*KEEP_W  packed keep, same packing
- s_axis_cmp_ready_o  out  N_CMP  per-source ready
- m_axis_tx_valid_o  out  1  to bit assembler
- m_axis_tx_last_o  out  1  end of frame
- m_axis_tx_data_o  out  DATA_W  data
- m_axis_tx_keep_o  out  KEEP_W  keep
- m_axis_tx_ready_i  in  1  from bit assembler

Behaviour:
- Reset (rst_n low, async): state IDLE; every output 0 (busy, done, cmp_sel, byte_cnt, all s ready, m valid/last/data/keep). Reset mid-frame aborts the frame; no done_o is produced.
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: all s ready low. start_i=1 -> cmp_sel<=0, byte_cnt<=0, busy<=1, go STREAM. start_i in any other state is ignored.
- STREAM: only s_axis_cmp_ready_o[cmp_sel] may be high; it equals (~m_valid | m_ready), combinational from registered m_valid and the m_axis_tx_ready_i input. All other ready bits are 0.
- Source handshake (valid & ready on selected source):
  - m_data<=data, m_keep<=keep, m_valid<=1 next cycle, so latency is 1 cycle.
  - m_last<=src_last & (cmp_sel==N_CMP-1); per-component last on earlier components is not forwarded.
  - byte_cnt += popcount(keep). Keep is not required to be contiguous. keep=0 beats are forwarded and add 0. byte_cnt wraps modulo 2^CNT_W with no saturation.
- Output register without a new source beat: m_valid<=0 when m_ready. Data, keep and last hold while m_valid & ~m_ready, as AXI requires.
- src_last on a component below N_CMP-1: cmp_sel increments the next cycle. No bubble is inserted; the next source may be accepted that cycle.
- src_last on component N_CMP-1: go DRAIN. All ready bits go low from the next cycle.
- Back-to-back throughput: one beat per cycle while the downstream ready stays high.
- DRAIN: wait for m_valid & m_ready (final beat) -> DONE.
- DONE: done_o=1 for exactly one cycle, busy<=0, go IDLE. byte_cnt_o and cmp_sel_o hold until the next start.
- Valid on non-selected sources is ignored and never lost (those sources stall). A selected source with valid low stalls the frame indefinitely; there is no timeout.
- N_CMP=1: a single source; last is forwarded directly.

Test Plan:
- Basic frame: N_CMP=3, sources send 2, 3, 1 full beats (keep=4'hF), downstream ready=1 -> 6 output beats in source order, m_last only on 6th, byte_cnt_o=24, done_o one pulse one cycle after the last handshake.
- Partial keep: last beats keep=4'b0001, 4'b0011, 4'b0111 on single-beat packets -> byte_cnt_o=6, keep passed unchanged.
- Backpressure: m_axis_tx_ready_i toggles 1/0 every cycle -> data/keep/last stable while stalled, no beat lost or duplicated, selected s ready mirrors (~m_valid|m_ready).
- Ordering: source 2 valid from cycle 0, source 0 valid late -> no source-2 beat accepted before source 0 and 1 lasts; source-2 ready stays 0 until cmp_sel=2.
- Control corner: start_i pulsed mid-frame -> ignored, byte_cnt continues; second start after done_o -> byte_cnt cleared to 0, cmp_sel=0.
- Reset mid-frame: rst_n low during component 1 -> all outputs 0 immediately, no done_o; a fresh start then completes a correct frame.
